serial_compare_ctrl: RTL



---
 rtl/comparator_pkg.sv | 24 ++
 rtl/bit_compare_slice.sv | 14 +
 rtl/serial_compare_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/comparator_pkg.sv
// Shared types for the serial comparator: FSM states, one-hot {GT,ET,LT}
// result encoding and the default operand width.
package comparator_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic gt;
    logic et;
    logic lt;
  } result_t;

  localparam result_t RES_NONE = 3'b000;
  localparam result_t RES_GT   = 3'b100;
  localparam result_t RES_ET   = 3'b010;
  localparam result_t RES_LT   = 3'b001;

endpackage

// File: rtl/bit_compare_slice.sv
// Single-bit magnitude comparator slice, time-shared by serial_compare_ctrl.
module bit_compare_slice (
  input  logic a,
  input  logic b,
  output logic gt,
  output logic et,
  output logic lt
);

  assign gt = a & ~b;
  assign lt = ~a & b;
  assign et = ~(a ^ b);

endmodule

// File: rtl/serial_compare_ctrl.sv
// MSB-first serial magnitude comparator using one shared bit slice.
// Optional macro SERIAL_COMPARE_CONST_TIME_EN gives data-independent latency.
module serial_compare_ctrl
  import comparator_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             GT,
  output logic             ET,
  output logic             LT
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  result_t            res_q, res_d;
  logic               slice_gt, slice_et, slice_lt;

`ifdef SERIAL_COMPARE_CONST_TIME_EN
  // Sticky record of the first differing bit; lower bits cannot overwrite it.
  logic               decided_q, decided_d;
  result_t            pend_q, pend_d;
`endif

  bit_compare_slice u_slice (
    .a  (a_q[idx_q]),
    .b  (b_q[idx_q]),
    .gt (slice_gt),
    .et (slice_et),
    .lt (slice_lt)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    res_d   = res_q;
`ifdef SERIAL_COMPARE_CONST_TIME_EN
    decided_d = decided_q;
    pend_d    = pend_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          idx_d   = IDX_W'(WIDTH - 1);
          res_d   = RES_NONE;
          state_d = SCAN;
`ifdef SERIAL_COMPARE_CONST_TIME_EN
          decided_d = 1'b0;
          pend_d    = RES_NONE;
`endif
        end
      end
      SCAN: begin
`ifdef SERIAL_COMPARE_CONST_TIME_EN
        if (!decided_q && !slice_et) begin
          decided_d = 1'b1;
          pend_d    = '{gt: slice_gt, et: 1'b0, lt: slice_lt};
        end
        if (idx_q == '0) begin
          state_d = DONE;
          if (decided_q)     res_d = pend_q;
          else if (slice_gt) res_d = RES_GT;
          else if (slice_lt) res_d = RES_LT;
          else               res_d = RES_ET;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
`else
        if (slice_gt) begin
          res_d   = RES_GT;
          state_d = DONE;
        end else if (slice_lt) begin
          res_d   = RES_LT;
          state_d = DONE;
        end else if (idx_q == '0) begin
          res_d   = RES_ET;
          state_d = DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= RES_NONE;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
    end
  end

  // Datapath registers are don't-care after reset, so they carry no reset.
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    idx_q <= idx_d;
`ifdef SERIAL_COMPARE_CONST_TIME_EN
    decided_q <= decided_d;
    pend_q    <= pend_d;
`endif
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign GT   = res_q.gt;
  assign ET   = res_q.et;
  assign LT   = res_q.lt;

endmodule
